// File: rtl/tile_eoc_ctrl_pkg.sv
// Shared types and constants for the tile boot / end-of-computation controller.
package tile_eoc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BOOT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Register window: eight word slots, six of them populated.
    localparam int unsigned RegWindowBytes = 32'h20;
    localparam int unsigned NumRegs        = 6;

    // Word indices (byte offset >> 2) within the window.
    localparam logic [2:0] REG_EXIT     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_BOOT     = 3'd2;
    localparam logic [2:0] REG_CYCLE_LO = 3'd3;
    localparam logic [2:0] REG_CYCLE_HI = 3'd4;
    localparam logic [2:0] REG_SCRATCH  = 3'd5;

    // STATUS register fields.
    localparam int unsigned STATUS_STATE_LSB = 0;
    localparam int unsigned STATUS_STATE_MSB = 1;

endpackage

// File: rtl/tile_eoc_ctrl_obi_regs.sv
// OBI subordinate register file: decode, one-cycle response stage, scratch and
// CYCLE_HI shadow. EXIT writes are only flagged here; the FSM owns the code.
module tile_eoc_ctrl_obi_regs
    import tile_eoc_ctrl_pkg::*;
#(
    parameter int unsigned            AddrWidth = 32,
    parameter logic [AddrWidth-1:0]   BaseAddr  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [AddrWidth-1:0] obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [3:0]           obi_be_i,
    input  logic [31:0]          obi_wdata_i,
    output logic                 obi_rvalid_o,
    output logic [31:0]          obi_rdata_o,
    output logic                 obi_err_o,
    input  state_e               state_i,
    input  logic [31:0]          boot_addr_i,
    input  logic [63:0]          cycle_cnt_i,
    input  logic [31:0]          exit_code_i,
    output logic                 exit_wr_o
);

    logic [2:0]  reg_idx;
    logic        unused_addr_bits;
    logic [31:0] rdata_d, rdata_q;
    logic        err_d, err_q;
    logic        rvalid_q;
    logic [31:0] scratch_d, scratch_q;
    logic [31:0] shadow_d, shadow_q;

    // The window is 0x20-aligned, so subtracting the base only touches addr[4:2].
    assign reg_idx          = obi_addr_i[4:2] - BaseAddr[4:2];
    assign unused_addr_bits = ^{obi_addr_i[AddrWidth-1:5], obi_addr_i[1:0]};

    assign obi_gnt_o    = obi_req_i;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;

    // Decode the current request into response data, error and side effects.
    always_comb begin
        rdata_d   = '0;
        err_d     = 1'b0;
        exit_wr_o = 1'b0;
        scratch_d = scratch_q;
        shadow_d  = shadow_q;
        if (obi_req_i) begin
            case (reg_idx)
                REG_EXIT: begin
                    if (!obi_we_i)             rdata_d   = exit_code_i;
                    else if (state_i == RUN)   exit_wr_o = 1'b1;
                    else                       err_d     = 1'b1;
                end
                REG_STATUS: begin
                    if (obi_we_i) err_d = 1'b1;
                    else          rdata_d[STATUS_STATE_MSB:STATUS_STATE_LSB] = state_i;
                end
                REG_BOOT: begin
                    if (obi_we_i) err_d   = 1'b1;
                    else          rdata_d = boot_addr_i;
                end
                REG_CYCLE_LO: begin
                    if (obi_we_i) begin
                        err_d = 1'b1;
                    end else begin
                        rdata_d  = cycle_cnt_i[31:0];
                        shadow_d = cycle_cnt_i[63:32];
                    end
                end
                REG_CYCLE_HI: begin
                    if (obi_we_i) err_d   = 1'b1;
                    else          rdata_d = shadow_q;
                end
                REG_SCRATCH: begin
                    if (obi_we_i) begin
                        for (int b = 0; b < 4; b++) begin
                            if (obi_be_i[b]) scratch_d[8*b +: 8] = obi_wdata_i[8*b +: 8];
                        end
                    end else begin
                        rdata_d = scratch_q;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Response stage and storage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            scratch_q <= '0;
            shadow_q  <= '0;
        end else begin
            rvalid_q  <= obi_req_i;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            scratch_q <= scratch_d;
            shadow_q  <= shadow_d;
        end
    end

endmodule

// File: rtl/tile_eoc_ctrl.sv
// Tile boot / end-of-computation controller.
//   state | meaning
//   IDLE  | waiting for the host fetch enable
//   BOOT  | boot address latched, one cycle before releasing the core
//   RUN   | core fetching, cycle counter running
//   DONE  | exit code latched, EOC raised, counter frozen
module tile_eoc_ctrl
    import tile_eoc_ctrl_pkg::*;
#(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 32,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fetch_en_i,
    input  logic [31:0]          boot_addr_i,
    output logic                 core_fetch_en_o,
    output logic [31:0]          core_boot_addr_o,
    output logic                 eoc_o,
    output logic [DataWidth-1:0] exit_code_o,
    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [AddrWidth-1:0] obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [3:0]           obi_be_i,
    input  logic [DataWidth-1:0] obi_wdata_i,
    output logic                 obi_rvalid_o,
    output logic [DataWidth-1:0] obi_rdata_o,
    output logic                 obi_err_o
);

    state_e      state_q, state_d;
    logic [31:0] boot_addr_q, boot_addr_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic [63:0] cycle_q, cycle_d;
    logic        exit_wr;

    // Next state; a falling fetch enable always beats a same-cycle EXIT write.
    always_comb begin
        state_d     = state_q;
        boot_addr_d = boot_addr_q;
        exit_code_d = exit_code_q;
        cycle_d     = cycle_q;
        case (state_q)
            IDLE: begin
                if (fetch_en_i) begin
                    boot_addr_d = boot_addr_i;
                    cycle_d     = '0;
                    state_d     = BOOT;
                end
            end
            BOOT: state_d = fetch_en_i ? RUN : IDLE;
            RUN: begin
                cycle_d = cycle_q + 64'd1;
                if (!fetch_en_i) begin
                    state_d = IDLE;
                end else if (exit_wr) begin
                    exit_code_d = obi_wdata_i;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (!fetch_en_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, boot address, exit code and cycle counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            boot_addr_q <= '0;
            exit_code_q <= '0;
            cycle_q     <= '0;
        end else begin
            state_q     <= state_d;
            boot_addr_q <= boot_addr_d;
            exit_code_q <= exit_code_d;
            cycle_q     <= cycle_d;
        end
    end

    assign core_fetch_en_o  = (state_q == RUN) || (state_q == DONE);
    assign eoc_o            = (state_q == DONE);
    assign core_boot_addr_o = boot_addr_q;
    assign exit_code_o      = exit_code_q;

    tile_eoc_ctrl_obi_regs #(
        .AddrWidth (AddrWidth),
        .BaseAddr  (BaseAddr)
    ) u_obi_regs (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rdata_o  (obi_rdata_o),
        .obi_err_o    (obi_err_o),
        .state_i      (state_q),
        .boot_addr_i  (boot_addr_q),
        .cycle_cnt_i  (cycle_q),
        .exit_code_i  (exit_code_q),
        .exit_wr_o    (exit_wr)
    );

endmodule
